// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, press/release debounce, and a
// two-deep history of accepted hex codes feeding a dual seven-segment display.
module keypad_scanner #(
  parameter int SCAN_DIV        = 24000,
  parameter int DEBOUNCE_CYCLES = 960000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right,
  output logic       new_key
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t          state_reg, state_next;
  logic [3:0]      rows_meta_reg;
  logic [3:0]      rs_reg;
  logic [1:0]      col_reg, col_next;
  logic [3:0]      cols_reg, cols_next;
  logic [DW-1:0]   dwell_reg, dwell_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [3:0]      pat_reg, pat_next;
  logic [1:0]      row_reg, row_next;
  logic [3:0]      left_reg, left_next;
  logic [3:0]      right_reg, right_next;
  logic            new_key_reg, new_key_next;

  logic [3:0]      rs_low;
  logic            one_low;
  logic [1:0]      low_row;

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'hE;
      4'hD:    code = 4'h0;
      4'hE:    code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // A single low row identifies the key; several low rows in one column are ambiguous.
  assign rs_low  = ~rs_reg;
  assign one_low = (rs_low != 4'd0) && ((rs_low & (rs_low - 4'd1)) == 4'd0);

  always_comb begin
    low_row = 2'd3;
    if (rs_low[0])      low_row = 2'd0;
    else if (rs_low[1]) low_row = 2'd1;
    else if (rs_low[2]) low_row = 2'd2;
  end

  always_comb begin
    state_next   = state_reg;
    col_next     = col_reg;
    dwell_next   = dwell_reg;
    cnt_next     = cnt_reg;
    pat_next     = pat_reg;
    row_next     = row_reg;
    left_next    = left_reg;
    right_next   = right_reg;
    new_key_next = 1'b0;

    case (state_reg)
      SCAN: begin
        if (dwell_reg == DWELL_LAST) begin
          if (one_low) begin
            state_next = DEBOUNCE;
            pat_next   = rs_reg;
            row_next   = low_row;
            cnt_next   = '0;
          end else begin
            col_next   = col_reg + 2'd1;
            dwell_next = '0;
          end
        end else begin
          dwell_next = dwell_reg + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (rs_reg == pat_reg) begin
          if (cnt_reg == CNT_LAST) begin
            state_next   = HELD;
            left_next    = right_reg;
            right_next   = key_code(row_reg, col_reg);
            new_key_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end else begin
          state_next = SCAN;
          dwell_next = '0;
        end
      end

      HELD: begin
        if (rs_reg == 4'hF) begin
          state_next = RELEASE;
          cnt_next   = '0;
        end
      end

      RELEASE: begin
        if (rs_reg != 4'hF) begin
          state_next = HELD;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = SCAN;
          col_next   = col_reg + 2'd1;
          dwell_next = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end

      default: state_next = SCAN;
    endcase
  end

  // Column drives come straight from flops so the pins never glitch.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col_drive
      assign cols_next[gi] = (col_next != 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_meta_reg <= 4'hF;
      rs_reg        <= 4'hF;
      state_reg     <= SCAN;
      col_reg       <= 2'd0;
      cols_reg      <= 4'b1110;
      dwell_reg     <= '0;
      cnt_reg       <= '0;
      pat_reg       <= 4'hF;
      row_reg       <= 2'd0;
      left_reg      <= 4'd0;
      right_reg     <= 4'd0;
      new_key_reg   <= 1'b0;
    end else begin
      rows_meta_reg <= rows;
      rs_reg        <= rows_meta_reg;
      state_reg     <= state_next;
      col_reg       <= col_next;
      cols_reg      <= cols_next;
      dwell_reg     <= dwell_next;
      cnt_reg       <= cnt_next;
      pat_reg       <= pat_next;
      row_reg       <= row_next;
      left_reg      <= left_next;
      right_reg     <= right_next;
      new_key_reg   <= new_key_next;
    end
  end

  assign cols        = cols_reg;
  assign digit_left  = left_reg;
  assign digit_right = right_reg;
  assign new_key     = new_key_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, reference model of the
// scan/debounce rules with a history of accepted codes, per-cycle compare.
module tb_keypad_scanner;

  localparam int S = 4;
  localparam int D = 8;

  localparam int P_SCAN    = 0;
  localparam int P_CONFIRM = 1;
  localparam int P_HELD    = 2;
  localparam int P_RELEASE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] digit_left;
  logic [3:0] digit_right;
  logic       new_key;

  logic [3:0][3:0] key_down;  // key_down[row][col]

  int total = 0;
  int bad = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  keypad_scanner #(.SCAN_DIV(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .digit_left(digit_left),
    .digit_right(digit_right),
    .new_key(new_key)
  );

  // Physical keypad: a pressed key pulls its row low when its column is driven low.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_down[r][c] && !cols[c]) rows[r] = 1'b0;
  end

  // Reference model
  int key_map [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};
  int         m_phase, m_col, m_dwell, m_cnt, m_row, m_lows;
  logic [3:0] m_pat, m_meta, m_rs, m_seen;
  bit         m_pulse;
  int         accepted[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = P_SCAN; m_col = 0; m_dwell = 0; m_cnt = 0; m_row = 0;
      m_pat = 4'hF; m_meta = 4'hF; m_rs = 4'hF; m_pulse = 1'b0;
      accepted.delete();
    end else begin
      m_seen = 4'hF;
      for (int r = 0; r < 4; r++) if (key_down[r][m_col]) m_seen[r] = 1'b0;
      m_lows = 0;
      for (int r = 0; r < 4; r++) if (!m_rs[r]) m_lows++;
      m_pulse = 1'b0;
      if (m_phase == P_SCAN) begin
        if (m_dwell == S - 1) begin
          if (m_lows == 1) begin
            m_phase = P_CONFIRM; m_pat = m_rs; m_cnt = 0;
            for (int r = 0; r < 4; r++) if (!m_rs[r]) m_row = r;
          end else begin
            m_col = (m_col + 1) % 4; m_dwell = 0;
          end
        end else m_dwell++;
      end else if (m_phase == P_CONFIRM) begin
        if (m_rs != m_pat) begin
          m_phase = P_SCAN; m_dwell = 0;
        end else if (m_cnt == D - 1) begin
          m_phase = P_HELD; m_pulse = 1'b1;
          accepted.push_back(key_map[m_row][m_col]);
        end else m_cnt++;
      end else if (m_phase == P_HELD) begin
        if (m_rs == 4'hF) begin m_phase = P_RELEASE; m_cnt = 0; end
      end else begin
        if (m_rs != 4'hF) m_phase = P_HELD;
        else if (m_cnt == D - 1) begin
          m_phase = P_SCAN; m_col = (m_col + 1) % 4; m_dwell = 0;
        end else m_cnt++;
      end
      m_rs = m_meta;
      m_meta = m_seen;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [3:0] exp_cols, exp_left, exp_right;
  always @(negedge clk) begin
    exp_cols  = ~(4'b0001 << m_col);
    exp_right = (accepted.size() > 0) ? 4'(accepted[accepted.size()-1]) : 4'd0;
    exp_left  = (accepted.size() > 1) ? 4'(accepted[accepted.size()-2]) : 4'd0;
    chk("cols", cols, exp_cols);
    chk("digit_left", digit_left, exp_left);
    chk("digit_right", digit_right, exp_right);
    chk("new_key", new_key, m_pulse);
    if (new_key === 1'b1) pulses++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  int p0;
  int mode, r1, c1, r2, c2, hold;
  bit bouncy, down;

  initial begin
    key_down = '0;
    reset = 1'b1;
    cyc(2);
    chk("rst_cols", cols, 4'b1110);
    chk("rst_left", digit_left, 4'd0);
    chk("rst_right", digit_right, 4'd0);
    chk("rst_new_key", new_key, 1'b0);
    cyc(1);
    reset = 1'b0;

    // Idle scan: each column held for S cycles.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_cols = ~(4'b0001 << ((i / S) % 4));
      chk("idle_scan_cols", cols, exp_cols);
    end
    cyc(1);

    // Press '5' and hold.
    p0 = pulses;
    key_down[1][1] = 1'b1;
    cyc(200);
    chk("t2_pulses", pulses - p0, 1);
    chk("t2_left", digit_left, 4'h0);
    chk("t2_right", digit_right, 4'h5);
    chk("t2_cols_frozen", cols, 4'b1101);
    key_down = '0;
    cyc(20);
    chk("t2_pulses_after", pulses - p0, 1);

    // 'A' then '0'.
    p0 = pulses;
    key_down[0][3] = 1'b1; cyc(60); key_down = '0; cyc(30);
    chk("t3_pulses_a", pulses - p0, 1);
    chk("t3_left_a", digit_left, 4'h5);
    chk("t3_right_a", digit_right, 4'hA);
    key_down[3][1] = 1'b1; cyc(60); key_down = '0; cyc(30);
    chk("t3_pulses_0", pulses - p0, 2);
    chk("t3_left_0", digit_left, 4'hA);
    chk("t3_right_0", digit_right, 4'h0);

    // Bouncing '9' never settles long enough.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      key_down[2][2] = 1'b1; cyc(3);
      key_down[2][2] = 1'b0; cyc(2);
    end
    cyc(30);
    chk("t4_pulses", pulses - p0, 0);
    chk("t4_left", digit_left, 4'hA);
    chk("t4_right", digit_right, 4'h0);

    // '1' and '4' share column 0: ambiguous, never accepted.
    p0 = pulses;
    key_down[0][0] = 1'b1; key_down[1][0] = 1'b1;
    cyc(100);
    chk("t5_dual_pulses", pulses - p0, 0);
    key_down = '0; cyc(30);
    // 'E' and '0' in different columns: exactly one accepted.
    p0 = pulses;
    key_down[3][0] = 1'b1; cyc(1); key_down[3][1] = 1'b1;
    cyc(100);
    key_down = '0; cyc(40);
    chk("t5_split_pulses", pulses - p0, 1);
    chk("t5_split_left", digit_left, 4'h0);
    chk("t5_split_right_is_e_or_0", (digit_right == 4'hE) || (digit_right == 4'h0), 1);

    // Hold 'F', release with a bounce: one pulse.
    p0 = pulses;
    key_down[3][2] = 1'b1; cyc(60);
    key_down[3][2] = 1'b0; cyc(4);
    key_down[3][2] = 1'b1; cyc(4);
    key_down[3][2] = 1'b0; cyc(40);
    chk("t6_bounce_pulses", pulses - p0, 1);
    chk("t6_right", digit_right, 4'hF);
    // Hold 'F' again, reset while held, re-detect after reset.
    key_down[3][2] = 1'b1; cyc(60);
    chk("t6_left_ff", digit_left, 4'hF);
    chk("t6_right_ff", digit_right, 4'hF);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_cols", cols, 4'b1110);
    chk("t6_rst_left", digit_left, 4'h0);
    chk("t6_rst_right", digit_right, 4'h0);
    chk("t6_rst_new_key", new_key, 1'b0);
    cyc(3);
    reset = 1'b0;
    p0 = pulses;
    cyc(60);
    chk("t6_reaccept_pulses", pulses - p0, 1);
    chk("t6_reaccept_left", digit_left, 4'h0);
    chk("t6_reaccept_right", digit_right, 4'hF);
    key_down = '0; cyc(30);

    // Randomized presses, combinations, bounces and resets against the model.
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 3);
      r1 = $urandom_range(0, 3); c1 = $urandom_range(0, 3);
      r2 = $urandom_range(0, 3); c2 = $urandom_range(0, 3);
      hold = $urandom_range(0, 60);
      bouncy = ($urandom_range(0, 2) == 0);
      for (int h = 0; h < hold; h++) begin
        down = bouncy ? ($urandom_range(0, 3) != 0) : 1'b1;
        key_down = '0;
        key_down[r1][c1] = down;
        if (mode == 3) key_down[r2][c2] = down;
        cyc(1);
      end
      key_down = '0;
      if ($urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        cyc($urandom_range(1, 2));
        reset = 1'b0;
      end
      cyc($urandom_range(0, 30));
    end
    cyc(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
